// File: rtl/spi_fl_seq_pkg.sv
// Shared definitions for the SPI flash operation sequencer.
// Purpose : opcodes, master commtype encodings, host op encodings, the
//           sequencer state enum and the per-step frame selector.
// Ports   : none (package).
// Config  : SPI_FL_SEQ_VERIFY_EN (used by spi_fl_seq) enables program read-back.
package spi_fl_seq_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = 8;
    localparam int unsigned CT_W   = 3;
    localparam int unsigned NB_W   = 7;
    localparam int unsigned STEP_W = 2;
    localparam int unsigned POLL_W = 16;

    // Flash opcodes
    localparam logic [CMD_W-1:0] OPC_READ = 8'h03;
    localparam logic [CMD_W-1:0] OPC_PP   = 8'h02;
    localparam logic [CMD_W-1:0] OPC_WREN = 8'h06;
    localparam logic [CMD_W-1:0] OPC_RDSR = 8'h05;
    localparam logic [CMD_W-1:0] OPC_SE   = 8'h20;

    // Master frame types
    localparam logic [CT_W-1:0] CT_CMD     = 3'b000;
    localparam logic [CT_W-1:0] CT_CMD_RD  = 3'b001;
    localparam logic [CT_W-1:0] CT_ADDR_WR = 3'b010;
    localparam logic [CT_W-1:0] CT_ADDR_RD = 3'b100;

    // Host request ops
    localparam logic [1:0] REQ_READ  = 2'b00;
    localparam logic [1:0] REQ_PROG  = 2'b01;
    localparam logic [1:0] REQ_ERASE = 2'b10;
    localparam logic [1:0] REQ_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4,
        ST_GAP       = 3'd5,
        ST_RESP      = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [CT_W-1:0]  ct;
        logic [NB_W-1:0]  ndata;
    } frame_t;

    // Step map: 0 WREN, 1 PP/SE, 2 RDSR poll, 3 read-back; reads always use READ.
    function automatic frame_t frame_sel(input logic [1:0] op, input logic [STEP_W-1:0] step);
        frame_t f;
        f = '{cmd: OPC_RDSR, ct: CT_CMD_RD, ndata: NB_W'(8)};
        if (op == REQ_READ || step == STEP_W'(3)) begin
            f = '{cmd: OPC_READ, ct: CT_ADDR_RD, ndata: NB_W'(32)};
        end else if (step == STEP_W'(0)) begin
            f = '{cmd: OPC_WREN, ct: CT_CMD, ndata: NB_W'(0)};
        end else if (step == STEP_W'(1)) begin
            if (op == REQ_PROG) begin
                f = '{cmd: OPC_PP, ct: CT_ADDR_WR, ndata: NB_W'(32)};
            end else begin
                f = '{cmd: OPC_SE, ct: CT_ADDR_WR, ndata: NB_W'(0)};
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/spi_fl_frame_if.sv
// Single-frame handshake with spi_master_fl.
// Purpose : latch frame fields on start, pulse m_validflag once the master is
//           idle, wait for busy then idle again, capture received data.
// Ports   : start/frame/addr/wdata in from sequencer; done pulse and rdata out;
//           m_* controller fields out to the master; m_data_out,
//           m_validflag_out, m_tready in from the master.
module spi_fl_frame_if
    import spi_fl_seq_pkg::*;
#(
    parameter int unsigned BUSY_GUARD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  frame_t            frame,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] m_data_in,
    output logic [ADDR_W-1:0] m_address,
    output logic [CMD_W-1:0]  m_command,
    output logic [CT_W-1:0]   m_commtype,
    output logic [NB_W-1:0]   m_ndata_bits,
    output logic              m_validflag,
    input  logic [DATA_W-1:0] m_data_out,
    input  logic              m_validflag_out,
    input  logic              m_tready
);

    localparam int unsigned GUARD_W = 8;

    seq_state_e        state_q, state_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [CT_W-1:0]   ct_q, ct_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              vf_q, vf_d;
    logic              done_q, done_d;

    // Frame handshake next-state
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        cmd_d   = cmd_q;
        ct_d    = ct_q;
        nb_d    = nb_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        vf_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmd_d   = frame.cmd;
                    ct_d    = frame.ct;
                    nb_d    = frame.ndata;
                    addr_d  = addr;
                    din_d   = wdata;
                    rdata_d = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (m_tready) begin
                    vf_d    = 1'b1;
                    guard_d = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // A master that never shows busy is treated as having finished.
                if (!m_tready) begin
                    state_d = ST_WAIT_DONE;
                end else if (guard_q == GUARD_W'(BUSY_GUARD - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (m_tready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (m_validflag_out && state_q != ST_IDLE) begin
            rdata_d = m_data_out;
        end
    end

    // Handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            guard_q <= '0;
            cmd_q   <= '0;
            ct_q    <= '0;
            nb_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            vf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            cmd_q   <= cmd_d;
            ct_q    <= ct_d;
            nb_q    <= nb_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            vf_q    <= vf_d;
            done_q  <= done_d;
        end
    end

    assign done         = done_q;
    assign rdata        = rdata_q;
    assign m_data_in    = din_q;
    assign m_address    = addr_q;
    assign m_command    = cmd_q;
    assign m_commtype   = ct_q;
    assign m_ndata_bits = nb_q;
    assign m_validflag  = vf_q;

endmodule

// File: rtl/spi_fl_seq.sv
// SPI flash operation sequencer.
// Purpose : turns host read/program/erase requests into WREN, operation and
//           RDSR polling frames for spi_master_fl, one frame at a time.
// Ports   : clk, rst (sync, active high); req_* host request in, req_ready out;
//           resp_* completion out; m_* controller fields to the master and
//           m_data_out/m_validflag_out/m_tready back from it.
// Config  : define SPI_FL_SEQ_VERIFY_EN to read back and compare programmed data.
module spi_fl_seq
    import spi_fl_seq_pkg::*;
#(
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned POLL_MAX   = 65535,
    parameter int unsigned BUSY_GUARD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DATA_W-1:0] m_data_in,
    output logic [ADDR_W-1:0] m_address,
    output logic [CMD_W-1:0]  m_command,
    output logic [CT_W-1:0]   m_commtype,
    output logic [NB_W-1:0]   m_ndata_bits,
    output logic [9:0]        m_frame_struct,
    output logic [3:0]        m_dummy_cycles,
    output logic              m_validflag,
    input  logic [DATA_W-1:0] m_data_out,
    input  logic              m_validflag_out,
    input  logic              m_tready
);

    localparam int unsigned GAP_W = 16;

    seq_state_e        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              start_q, start_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    frame_t            cur_frame;
    logic [DATA_W-1:0] frame_wdata;
    logic              frame_done;
    logic [DATA_W-1:0] frame_rdata;

    assign cur_frame   = frame_sel(op_q, step_q);
    assign frame_wdata = (cur_frame.cmd == OPC_PP) ? wdata_q : '0;

    // Operation sequencer next-state
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        step_d       = step_q;
        poll_d       = poll_q;
        gap_d        = gap_q;
        start_d      = 1'b0;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    step_d      = '0;
                    poll_d      = '0;
                    req_ready_d = 1'b0;
                    if (req_op == REQ_RSVD) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                start_d = 1'b1;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (frame_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (op_q == REQ_READ || step_q == STEP_W'(3)) begin
                    // Plain read, or program read-back compared against wdata.
                    resp_valid_d = 1'b1;
                    resp_rdata_d = frame_rdata;
                    resp_err_d   = (op_q != REQ_READ) && (frame_rdata != wdata_q);
                    state_d      = ST_RESP;
                end else if (step_q != STEP_W'(2)) begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = ST_LAUNCH;
                end else begin
                    poll_d = poll_q + POLL_W'(1);
                    if (!frame_rdata[0]) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                        state_d      = ST_RESP;
`ifdef SPI_FL_SEQ_VERIFY_EN
                        if (op_q == REQ_PROG) begin
                            resp_valid_d = 1'b0;
                            step_d       = STEP_W'(3);
                            state_d      = ST_LAUNCH;
                        end
`endif
                    end else if (poll_d == POLL_W'(POLL_MAX)) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = ST_LAUNCH;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_RESP: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            step_q       <= '0;
            poll_q       <= '0;
            gap_q        <= '0;
            start_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            step_q       <= step_d;
            poll_q       <= poll_d;
            gap_q        <= gap_d;
            start_q      <= start_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    spi_fl_frame_if #(
        .BUSY_GUARD (BUSY_GUARD)
    ) u_frame_if (
        .clk             (clk),
        .rst             (rst),
        .start           (start_q),
        .frame           (cur_frame),
        .addr            (addr_q),
        .wdata           (frame_wdata),
        .done            (frame_done),
        .rdata           (frame_rdata),
        .m_data_in       (m_data_in),
        .m_address       (m_address),
        .m_command       (m_command),
        .m_commtype      (m_commtype),
        .m_ndata_bits    (m_ndata_bits),
        .m_validflag     (m_validflag),
        .m_data_out      (m_data_out),
        .m_validflag_out (m_validflag_out),
        .m_tready        (m_tready)
    );

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign m_frame_struct = 10'h000;
    assign m_dummy_cycles = 4'h0;

endmodule

// File: tb/tb_spi_fl_seq.sv
// Testbench for spi_fl_seq with a small behavioural flash/master model.
// Expected frames and responses are queued as each request is issued and
// compared as the DUT launches frames and completes.
module tb_spi_fl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] m_data_in;
    logic [23:0] m_address;
    logic [7:0]  m_command;
    logic [2:0]  m_commtype;
    logic [6:0]  m_ndata_bits;
    logic [9:0]  m_frame_struct;
    logic [3:0]  m_dummy_cycles;
    logic        m_validflag;
    logic [31:0] m_data_out;
    logic        m_validflag_out;
    logic        m_tready;

    spi_fl_seq #(.POLL_GAP(16), .POLL_MAX(4), .BUSY_GUARD(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_data_in(m_data_in), .m_address(m_address), .m_command(m_command),
        .m_commtype(m_commtype), .m_ndata_bits(m_ndata_bits),
        .m_frame_struct(m_frame_struct), .m_dummy_cycles(m_dummy_cycles),
        .m_validflag(m_validflag), .m_data_out(m_data_out),
        .m_validflag_out(m_validflag_out), .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic [73:0] exp_frm[$];
    logic [32:0] exp_resp[$];
    logic [7:0]  st_q[$];
    logic [7:0]  stuck     = 8'h00;
    logic [31:0] rd_word   = 32'h0;
    bit          hold_busy = 1'b0;
    bit          model_busy = 1'b0;
    int          launches  = 0;
    int          vf_cnt    = 0;
    int          resp_cnt  = 0;
    int          last_end  = 0;
    logic [7:0]  last_cmd  = 8'h00;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [73:0] mk(input logic [7:0] c, input logic [2:0] t,
                                        input logic [6:0] n, input logic [23:0] a,
                                        input logic [31:0] d);
        return {c, t, n, a, d};
    endfunction

    // Flash + master model: busy for a few cycles per frame, returns read/status data
    initial begin
        logic [7:0]  cmd_seen;
        logic [7:0]  stat;
        logic [23:0] a_obs;
        logic [31:0] d_obs;
        m_tready = 1'b1;
        m_validflag_out = 1'b0;
        m_data_out = 32'h0;
        forever begin
            @(negedge clk);
            if (m_validflag && m_tready && !rst) begin
                launches++;
                model_busy = 1'b1;
                cmd_seen = m_command;
                a_obs = (m_commtype == 3'b010 || m_commtype == 3'b100) ? m_address : 24'h0;
                d_obs = (m_command == 8'h02) ? m_data_in : 32'h0;
                if (exp_frm.size() == 0)
                    chk("extra_frame", {m_command, m_commtype, m_ndata_bits, a_obs, d_obs}, 128'h0);
                else
                    chk("frame", {m_command, m_commtype, m_ndata_bits, a_obs, d_obs}, exp_frm.pop_front());
                chk("fstruct_dummy", {m_frame_struct, m_dummy_cycles}, 128'h0);
                if (cmd_seen == 8'h05 && last_cmd == 8'h05)
                    chk("poll_gap_ge16", (cyc - last_end) >= 16, 1);
                m_tready = 1'b0;
                repeat (3) @(negedge clk);
                if (cmd_seen == 8'h03) begin
                    m_validflag_out = 1'b1;
                    m_data_out = rd_word;
                end else if (cmd_seen == 8'h05) begin
                    stat = (st_q.size() > 0) ? st_q.pop_front() : stuck;
                    m_validflag_out = 1'b1;
                    m_data_out = {24'h0, stat};
                end
                @(negedge clk);
                m_validflag_out = 1'b0;
                m_data_out = 32'h0;
                m_tready = 1'b1;
                last_end = cyc;
                last_cmd = cmd_seen;
                model_busy = 1'b0;
            end else begin
                m_tready = !hold_busy;
            end
        end
    end

    // Launch pulse counter
    initial forever begin
        @(negedge clk);
        if (m_validflag) vf_cnt++;
    end

    // Response scoreboard
    initial forever begin
        @(negedge clk);
        if (resp_valid) begin
            resp_cnt++;
            if (exp_resp.size() == 0)
                chk("extra_resp", {resp_err, resp_rdata}, 128'h0);
            else
                chk("resp", {resp_err, resp_rdata}, exp_resp.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d);
        @(negedge clk);
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n0, input string tag);
        bit hi = 1'b0;
        for (int i = 0; i < 3000 && resp_cnt == n0; i++) begin
            if (req_ready) hi = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_resp_seen"}, resp_cnt == n0 + 1, 1);
        chk({tag, "_ready_low"}, hi, 0);
        @(negedge clk);
        chk({tag, "_ready_after"}, req_ready, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk(tag, {req_ready, resp_valid, resp_rdata, resp_err, m_data_in, m_address,
                  m_command, m_commtype, m_ndata_bits, m_frame_struct, m_dummy_cycles,
                  m_validflag}, {1'b1, 123'h0});
    endtask

    task automatic settle_model();
        for (int i = 0; i < 100 && model_busy; i++) @(negedge clk);
        chk("model_idle", model_busy, 0);
    endtask

    initial begin
        int n, f, v;
        bit seen;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_addr = 24'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset_outs");
        rst = 1'b0;

        // Read
        rd_word = 32'hA0A0A0A3;
        exp_frm.push_back(mk(8'h03, 3'b100, 7'd32, 24'h555555, 32'h0));
        exp_resp.push_back({1'b0, 32'hA0A0A0A3});
        n = resp_cnt; f = launches;
        issue(2'b00, 24'h555555, 32'h0);
        wait_resp(n, "read");
        chk("read_frames", launches - f, 1);

        // Program, WIP 1,1,0
        st_q = '{8'h01, 8'h01, 8'h00};
        rd_word = 32'h5A5A5A5A;
        exp_frm.push_back(mk(8'h06, 3'b000, 7'd0, 24'h0, 32'h0));
        exp_frm.push_back(mk(8'h02, 3'b010, 7'd32, 24'h000100, 32'h5A5A5A5A));
        repeat (3) exp_frm.push_back(mk(8'h05, 3'b001, 7'd8, 24'h0, 32'h0));
`ifdef SPI_FL_SEQ_VERIFY_EN
        exp_frm.push_back(mk(8'h03, 3'b100, 7'd32, 24'h000100, 32'h0));
        exp_resp.push_back({1'b0, 32'h5A5A5A5A});
`else
        exp_resp.push_back({1'b0, 32'h0});
`endif
        n = resp_cnt; f = launches;
        issue(2'b01, 24'h000100, 32'h5A5A5A5A);
        wait_resp(n, "prog");
        chk("prog_frames_left", exp_frm.size(), 0);

        // Erase with WIP stuck: POLL_MAX=4 polls then error
        stuck = 8'h01;
        exp_frm.push_back(mk(8'h06, 3'b000, 7'd0, 24'h0, 32'h0));
        exp_frm.push_back(mk(8'h20, 3'b010, 7'd0, 24'h012000, 32'h0));
        repeat (4) exp_frm.push_back(mk(8'h05, 3'b001, 7'd8, 24'h0, 32'h0));
        exp_resp.push_back({1'b1, 32'h0});
        n = resp_cnt; f = launches;
        issue(2'b10, 24'h012000, 32'h0);
        wait_resp(n, "erase");
        chk("erase_frames", launches - f, 6);
        stuck = 8'h00;

        // Reserved op: immediate error, no frames
        exp_resp.push_back({1'b1, 32'h0});
        n = resp_cnt; f = launches;
        issue(2'b11, 24'h000000, 32'h0);
        chk("rsvd_resp_next_cycle", resp_valid, 1);
        repeat (5) @(negedge clk);
        chk("rsvd_no_frames", launches - f, 0);
        chk("rsvd_one_resp", resp_cnt - n, 1);

        // Master busy at launch for 10 cycles
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        rd_word = 32'hCAFEF00D;
        exp_frm.push_back(mk(8'h03, 3'b100, 7'd32, 24'h000ABC, 32'h0));
        exp_resp.push_back({1'b0, 32'hCAFEF00D});
        n = resp_cnt; v = vf_cnt;
        issue(2'b00, 24'h000ABC, 32'h0);
        repeat (10) @(negedge clk);
        chk("vf_held_while_busy", vf_cnt - v, 0);
        hold_busy = 1'b0;
        wait_resp(n, "busy_read");
        chk("vf_single_pulse", vf_cnt - v, 1);

        // Reset during PP frame
        st_q = '{8'h00};
        exp_frm.push_back(mk(8'h06, 3'b000, 7'd0, 24'h0, 32'h0));
        exp_frm.push_back(mk(8'h02, 3'b010, 7'd32, 24'h000200, 32'h11112222));
        n = resp_cnt;
        issue(2'b01, 24'h000200, 32'h11112222);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (m_validflag && m_command == 8'h02) begin
                seen = 1'b1;
                break;
            end
        end
        chk("pp_launch_seen", seen, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("vf_low_after_rst", m_validflag, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outs("mid_op_reset_outs");
        settle_model();
        exp_frm.delete();
        st_q.delete();
        chk("no_resp_after_abort", resp_cnt - n, 0);

        rd_word = 32'h13572468;
        exp_frm.push_back(mk(8'h03, 3'b100, 7'd32, 24'h00F00F, 32'h0));
        exp_resp.push_back({1'b0, 32'h13572468});
        n = resp_cnt;
        issue(2'b00, 24'h00F00F, 32'h0);
        wait_resp(n, "read_after_rst");

        // Program with mismatching read-back
        st_q = '{8'h00};
        rd_word = 32'h12345670;
        exp_frm.push_back(mk(8'h06, 3'b000, 7'd0, 24'h0, 32'h0));
        exp_frm.push_back(mk(8'h02, 3'b010, 7'd32, 24'h000300, 32'h12345678));
        exp_frm.push_back(mk(8'h05, 3'b001, 7'd8, 24'h0, 32'h0));
`ifdef SPI_FL_SEQ_VERIFY_EN
        exp_frm.push_back(mk(8'h03, 3'b100, 7'd32, 24'h000300, 32'h0));
        exp_resp.push_back({1'b1, 32'h12345670});
`else
        exp_resp.push_back({1'b0, 32'h0});
`endif
        n = resp_cnt;
        issue(2'b01, 24'h000300, 32'h12345678);
        wait_resp(n, "prog_verify");
        settle_model();
        chk("frames_all_seen", exp_frm.size(), 0);
        chk("resps_all_seen", exp_resp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_fl_seq.md
Name: spi_fl_seq

Overview:
- Flash operation sequencer that sits between a host/CPU interface and spi_master_fl.
- Turns single host requests (read word, program word, sector erase) into the ordered SPI frame series the flash requires: WREN, then the operation, then status polling.
- Owns all of the master's controller-side fields (command, address, commtype, ndata_bits, frame_struct, dummy_cycles, validflag) and consumes data_out, validflag_out and tready.
- The master runs exactly one frame at a time; this block serialises them.

Parameters:
- POLL_GAP, 16: idle clk cycles between consecutive RDSR polls.
- POLL_MAX, 65535: maximum RDSR polls before timeout; 16-bit counter.
- BUSY_GUARD, 4: cycles to wait for m_tready to fall after a frame launch.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  block idle and accepting
- req_op  in  2  00 read, 01 program, 10 erase, 11 reserved
- req_addr  in  24  flash byte address
- req_wdata  in  32  program data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  read data (valid with resp_valid)
- resp_err  out  1  timeout/illegal-op/verify error (valid with resp_valid)
- m_data_in  out  32  to master data_in
- m_address  out  24  to master address
- m_command  out  8  to master command
- m_commtype  out  3  to master commtype
- m_ndata_bits  out  7  to master ndata_bits
- m_frame_struct  out  10  to master frame_struct, always 10'h000
- m_dummy_cycles  out  4  to master dummy_cycles, always 0
- m_validflag  out  1  frame launch pulse
- m_data_out  in  32  master received data
- m_validflag_out  in  1  master read data valid
- m_tready  in  1  master idle

Behaviour:
- Reset values:
  - req_ready=1; all other outputs 0.
  - State IDLE; poll and gap counters cleared.
  - rst mid-operation abandons the sequence immediately; m_validflag drops the same cycle rst is sampled.
- Accept: req_valid & req_ready captures req_op/addr/wdata; req_ready=0 next cycle until the cycle after resp_valid.
- Frame handshake (LAUNCH, WAIT_BUSY, WAIT_DONE), used for every frame:
  - LAUNCH: fields registered; m_validflag=1 for exactly one cycle, only when m_tready=1, otherwise hold in LAUNCH.
  - WAIT_BUSY: wait for m_tready=0; if it has not fallen after BUSY_GUARD cycles, the frame is treated as complete.
  - WAIT_DONE: wait for m_tready=1.
  - m_data_out is captured whenever m_validflag_out=1 during a frame.
  - Fields stay stable from LAUNCH until WAIT_DONE exits.
- Package frame encodings:
  - CT_CMD=3'b000, cmd only.
  - CT_CMD_RD=3'b001, cmd + read.
  - CT_ADDR_WR=3'b010, cmd + addr + write.
  - CT_ADDR_RD=3'b100, cmd + addr + read.
- Read: one frame, 0x03, CT_ADDR_RD, ndata 32 → RESP with resp_rdata=captured word, resp_err=0.
- Program:
  - WREN frame (0x06, CT_CMD, ndata 0).
  - PP frame (0x02, CT_ADDR_WR, ndata 32, m_data_in=wdata).
  - POLL loop.
- Erase: WREN, then SE (0x20, CT_ADDR_WR, ndata 0), then POLL loop.
- POLL loop:
  - RDSR frame (0x05, CT_CMD_RD, ndata 8); status is captured bits [7:0].
  - Bit0 (WIP)=0 → RESP.
  - Bit0=1 → GAP for POLL_GAP cycles, then reissue.
  - Poll count reaching POLL_MAX with WIP still 1 → RESP with resp_err=1.
- Reserved op: RESP the cycle after accept with resp_err=1; no frames launched.
- RESP: resp_valid=1 for one cycle; resp_rdata=0 for program/erase; next state IDLE.
- State list: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, NEXT (sequence step decode), GAP, RESP.
- Sequence step counter: 2 bits.

Optional Feature:
- Macro: SPI_FL_SEQ_VERIFY_EN.
- Defined: after a successful program poll, a read frame (0x03) at the same address runs; mismatch with wdata → resp_err=1; resp_rdata=read-back word.
- Undefined: program ends at WIP clear, with no read-back.

Decomposition:
- Package spi_fl_seq_pkg holds:
  - opcode constants (0x03/0x02/0x06/0x05/0x20);
  - CT_* commtype constants;
  - req_op encodings;
  - state enum.
- One natural sub-module: spi_fl_frame_if, the LAUNCH/WAIT_BUSY/WAIT_DONE handshake with the master plus data capture. The top level holds the op sequencer and poll counters.

Test Plan:
- Read addr 24'h555555, bench flash returns 32'hA0A0A0A3 → one frame cmd 0x03, resp_rdata=32'hA0A0A0A3, resp_err=0, req_ready low throughout.
- Program addr 24'h000100, wdata 32'h5A5A5A5A, status 0x01 twice then 0x00 → frames 0x06, 0x02, 0x05×3; gaps ≥16 cycles between polls; resp_err=0.
- Erase with WIP stuck at 1, POLL_MAX=4 → exactly 4 RDSR frames, then resp_valid with resp_err=1.
- m_tready held low at launch for 10 cycles → m_validflag stays 0 until m_tready=1, then exactly one pulse.
- rst asserted during the PP frame, then a read issued → block in IDLE with req_ready=1 after reset; read completes normally.
- With SPI_FL_SEQ_VERIFY_EN, program 32'h12345678, read-back 32'h12345670 → resp_err=1, resp_rdata=32'h12345670.
